// File: rtl/bitserial_pkg.sv
// Shared types and width helpers for the self-sequencing bit-serial MAC.
package bitserial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a signed column sum: one sign-extended lane term plus one bit per tree level.
  function automatic int unsigned tree_width(input int unsigned data_width,
                                             input int unsigned vec_length);
    return data_width + 1 + $clog2(vec_length);
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned w_mag_width,
                                            input int unsigned vec_length);
    return data_width + w_mag_width + $clog2(vec_length) + 1;
  endfunction

endpackage

// File: rtl/bs_column_reduce.sv
// Combinational lane select and adder tree producing the signed sum of one weight-bit column.
module bs_column_reduce
  import bitserial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  localparam int unsigned SUM_W     = tree_width(DATA_WIDTH, VEC_LENGTH)
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_i,
  input  logic [VEC_LENGTH-1:0]                 w_sign_i,
  input  logic [VEC_LENGTH-1:0]                 col_bits_i,
  output logic signed [SUM_W-1:0]               col_sum_o
);

  localparam int unsigned LEVELS = $clog2(VEC_LENGTH);

  logic signed [DATA_WIDTH:0] term [VEC_LENGTH];

  // Negation at DATA_WIDTH+1 bits keeps -(most negative activation) exact.
  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      term[j] = '0;
      if (col_bits_i[j]) begin
        term[j] = w_sign_i[j] ? -$signed({act_i[j][DATA_WIDTH-1], act_i[j]})
                              :  $signed({act_i[j][DATA_WIDTH-1], act_i[j]});
      end
    end
  end

  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int unsigned NW = DATA_WIDTH + 1 + lv;
    localparam int unsigned NN = VEC_LENGTH >> lv;
    logic signed [NW-1:0] node [NN];
    if (lv == 0) begin : g_leaf
      for (genvar i = 0; i < NN; i++) begin : g_n
        assign node[i] = term[i];
      end
    end else begin : g_add
      for (genvar i = 0; i < NN; i++) begin : g_n
        assign node[i] = NW'(g_lvl[lv-1].node[2*i]) + NW'(g_lvl[lv-1].node[2*i+1]);
      end
    end
  end

  assign col_sum_o = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/bitserial_mac_seq.sv
// Self-sequencing bit-serial dot-product unit: captures a vector, walks weight columns, returns the sum.
// Build option BITSERIAL_ZERO_COL_SKIP_EN visits only columns with at least one set weight bit.
module bitserial_mac_seq
  import bitserial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned W_MAG_WIDTH = 7,
  parameter int unsigned VEC_LENGTH  = 16,
  localparam int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, W_MAG_WIDTH, VEC_LENGTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_clear,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act,
  input  logic [VEC_LENGTH-1:0]                  w_sign,
  input  logic [VEC_LENGTH-1:0][W_MAG_WIDTH-1:0] w_mag,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [ACC_WIDTH-1:0]            result
);

  localparam int unsigned TREE_W = tree_width(DATA_WIDTH, VEC_LENGTH);
  localparam int unsigned COL_W  = (W_MAG_WIDTH > 1) ? $clog2(W_MAG_WIDTH) : 1;

  state_e state_q, state_d;
  logic [COL_W-1:0]                     col_q, col_d;
  logic signed [ACC_WIDTH-1:0]          acc_q, acc_d;
  logic                                 out_valid_q;
  logic                                 load;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_q;
  logic [VEC_LENGTH-1:0]                  w_sign_q;
  logic [VEC_LENGTH-1:0][W_MAG_WIDTH-1:0] w_mag_q;
  logic [VEC_LENGTH-1:0]                col_bits;
  logic signed [TREE_W-1:0]             col_sum;

`ifdef BITSERIAL_ZERO_COL_SKIP_EN
  logic [W_MAG_WIDTH-1:0] mask_q, mask_d, cap_mask, rem_mask;

  function automatic logic [COL_W-1:0] first_set(input logic [W_MAG_WIDTH-1:0] m);
    first_set = '0;
    for (int k = W_MAG_WIDTH - 1; k >= 0; k--) begin
      if (m[k]) first_set = COL_W'(k);
    end
  endfunction

  always_comb begin
    cap_mask = '0;
    for (int j = 0; j < VEC_LENGTH; j++) cap_mask = cap_mask | w_mag[j];
  end
`else
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W_MAG_WIDTH - 1);
`endif

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) col_bits[j] = w_mag_q[j][col_q];
  end

  bs_column_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH)
  ) u_reduce (
    .act_i      (act_q),
    .w_sign_i   (w_sign_q),
    .col_bits_i (col_bits),
    .col_sum_o  (col_sum)
  );

  // Next-state, column walk and accumulate.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    acc_d   = acc_q;
    load    = 1'b0;
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
    mask_d   = mask_q;
    rem_mask = '0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          col_d   = '0;
          state_d = RUN;
          if (in_clear) acc_d = '0;
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
          mask_d = cap_mask;
          col_d  = first_set(cap_mask);
          if (cap_mask == '0) state_d = DONE;
`endif
        end
      end
      RUN: begin
        acc_d = acc_q + (ACC_WIDTH'(col_sum) <<< col_q);
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
        // Keep only mask bits strictly above the column just accumulated.
        rem_mask = mask_q & ~((W_MAG_WIDTH'(2) << col_q) - W_MAG_WIDTH'(1));
        if (rem_mask == '0) state_d = DONE;
        else                col_d   = first_set(rem_mask);
`else
        if (col_q == LAST_COL) state_d = DONE;
        else                   col_d   = col_q + COL_W'(1);
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      out_valid_q <= (state_d == DONE);
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
      mask_q      <= mask_d;
`endif
    end
  end

  // Operand capture needs no reset: it is only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      act_q    <= act;
      w_sign_q <= w_sign;
      w_mag_q  <= w_mag;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Scoreboard bench for bitserial_mac_seq: directed spec vectors, backpressure, reset, random traffic.
module tb_bitserial_mac_seq;

  localparam int DW = 8;
  localparam int WM = 7;
  localparam int VL = 16;
  localparam int AW = DW + WM + $clog2(VL) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_clear = 1'b0;
  logic [VL-1:0][DW-1:0] act = '0;
  logic [VL-1:0]         w_sign = '0;
  logic [VL-1:0][WM-1:0] w_mag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [AW-1:0] result;

  int total = 0;
  int bad = 0;
  longint cyc = 0;
  longint acc_m = 0;
  bit rdy_rand = 1'b0;
  bit rdy_val = 1'b1;

  typedef struct {
    longint res;
    longint hs;
    int     lat;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  bit in_done = 1'b0;
  longint held = 0;

  bitserial_mac_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_clear  (in_clear),
    .act       (act),
    .w_sign    (w_sign),
    .w_mag     (w_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return longint'($signed(t));
  endfunction

  // Reference: plain signed dot product of activations with sign-magnitude weights.
  function automatic longint dot();
    longint s = 0;
    for (int j = 0; j < VL; j++) begin
      longint a = longint'($signed(act[j]));
      longint m = longint'(w_mag[j]);
      s += w_sign[j] ? -(a * m) : (a * m);
    end
    return s;
  endfunction

  function automatic int exp_lat();
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
    logic [WM-1:0] m = '0;
    for (int j = 0; j < VL; j++) m = m | w_mag[j];
    return (m == '0) ? 1 : $countones(m);
`else
    return WM;
`endif
  endfunction

  task automatic set_all(input logic [DW-1:0] a, input logic s, input logic [WM-1:0] m);
    for (int j = 0; j < VL; j++) begin
      act[j] = a;
      w_sign[j] = s;
      w_mag[j] = m;
    end
  endtask

  task automatic send(input logic clr);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got in_ready=0 want 1 within 200 cycles");
      return;
    end
    in_clear = clr;
    in_valid = 1'b1;
    acc_m = clr ? 0 : acc_m;
    acc_m = wrap(acc_m + dot());
    sbq.push_back('{res: acc_m, hs: cyc + 1, lat: exp_lat()});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sbq.size(), 0);
    @(negedge clk);
  endtask

  // out_ready changes just after the rising edge so the monitor sees it settled.
  initial forever begin
    @(posedge clk);
    #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Monitor: latency, stability under backpressure, and result against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      in_done = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_in_done", longint'(in_ready), 0);
      if (!in_done) begin
        in_done = 1'b1;
        held = result;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got=%0d want none", result);
        end else begin
          chk("latency", cyc - sbq[0].hs, longint'(sbq[0].lat));
        end
      end else begin
        chk("result_stable", result, held);
      end
      if (out_ready) begin
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("result", result, e.res);
        end
        in_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [WM-1:0] keep;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_result", result, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", longint'(in_ready), 1);

    // Directed vectors from the test plan.
    set_all(8'd1, 1'b0, 7'h7F);  send(1'b1);
    set_all(8'h80, 1'b1, 7'd1);  send(1'b1);
    set_all(8'd0, 1'b0, 7'd0);
    act[0] = 8'd5; w_sign[0] = 1'b1; w_mag[0] = 7'd3;
    send(1'b1);
    set_all(8'd1, 1'b0, 7'h7F);  send(1'b0);
    set_all(8'd1, 1'b0, 7'h40);  send(1'b1);
    set_all(8'd1, 1'b0, 7'h00);  send(1'b0);
    wait_drain();

    // Backpressure: result held, inputs ignored in DONE including the release edge.
    rdy_val = 1'b0;
    @(posedge clk);
    set_all(8'd3, 1'b1, 7'h15);
    send(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk("bp_reach_done", longint'(out_valid), 1);
    held = result;
    set_all(8'h7F, 1'b0, 7'h7F);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_result", result, held);
    end
    rdy_val = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", longint'(in_ready), 1);
    chk("bp_release_out_valid", longint'(out_valid), 0);
    wait_drain();

    // Reset on the third RUN cycle abandons the operation.
    set_all(8'd2, 1'b0, 7'h7F);
    send(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrun_rst_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrun_out_valid", longint'(out_valid), 0);
    chk("midrun_result", result, 0);
    reset = 1'b0;
    acc_m = 0;
    set_all(8'd1, 1'b0, 7'h7F);
    send(1'b0);
    wait_drain();

    // Random traffic with random output backpressure.
    rdy_rand = 1'b1;
    repeat (40) begin
      for (int j = 0; j < VL; j++) begin
        act[j] = DW'($urandom);
        w_sign[j] = 1'($urandom);
        w_mag[j] = WM'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        keep = WM'($urandom) & WM'($urandom);
        for (int j = 0; j < VL; j++) w_mag[j] = w_mag[j] & keep;
      end
      send(1'($urandom_range(0, 2) == 0));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitserial_mac_seq.md
Name: bitserial_mac_seq

Overview:
Self-sequencing bit-serial dot-product unit for the BitSim PE array.
- Accepts one vector of VEC_LENGTH signed activations plus sign-magnitude weights through a valid/ready handshake.
- Walks the weight-magnitude bit columns internally, one column per cycle, with an internal counter.
- Accumulates the shifted column sums and returns the result through an output valid/ready handshake.
- Generalises the fixed 8-lane, externally column-indexed MAC to parametrised lanes, weight width and chaining.

Parameters:
DATA_WIDTH, 8, activation width (signed two's complement)
W_MAG_WIDTH, 7, weight magnitude bits; the weight sign is carried separately
VEC_LENGTH, 16, lane count; must be a power of 2 and at least 2
ACC_WIDTH (localparam), DATA_WIDTH+W_MAG_WIDTH+$clog2(VEC_LENGTH)+1, accumulator and result width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_clear  in  1  sampled at input handshake; 1 = start accumulator from 0, 0 = add onto the previous result
act  in  [VEC_LENGTH][DATA_WIDTH]  signed activations
w_sign  in  [VEC_LENGTH]  weight sign per lane (1 = negative)
w_mag  in  [VEC_LENGTH][W_MAG_WIDTH]  weight magnitude per lane
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
result  out  ACC_WIDTH  signed accumulated dot product

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE, acc=0, col=0, out_valid=0, result=0.
  - in_ready=0 while reset is high.
  - Reset mid-RUN or mid-DONE abandons the operation; no partial result is visible.
- FSM states: IDLE, RUN, DONE.
  - in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid&&in_ready, register act, w_sign, w_mag.
  - col=0.
  - acc=0 if in_clear, else acc is kept.
  - Next state is RUN.
- RUN, each cycle:
  - Lane term = w_mag[j][col] ? (w_sign[j] ? -act[j] : act[j]) : 0.
  - Negation is done at DATA_WIDTH+1 bits, so -(-128) = +128 is exact.
  - Adder tree grows 1 bit per level, depth $clog2(VEC_LENGTH).
  - The column sum is sign-extended and shifted left by col, then added to acc.
  - If col==W_MAG_WIDTH-1, go to DONE; else col+1.
- Latency: out_valid rises exactly W_MAG_WIDTH clock edges after the input handshake edge.
- DONE: result==acc and is held stable while out_ready=0.
  - On out_ready=1, go to IDLE at the next edge.
  - in_valid is ignored in DONE, including the out_ready edge; the earliest next accept is the following cycle.
- Throughput: one vector per W_MAG_WIDTH+2 cycles.
- Overflow:
  - A single vector can never overflow ACC_WIDTH.
  - Chaining with in_clear=0 wraps modulo 2^ACC_WIDTH with no saturation.

Optional Feature:
Macro BITSERIAL_ZERO_COL_SKIP_EN.
- Defined:
  - At capture, register col_mask[k] = OR over lanes of w_mag[j][k].
  - RUN visits only columns with col_mask=1, in ascending order. col loads the first set bit; after each accumulate it jumps to the next set bit.
  - DONE follows the last set bit, so latency = popcount(col_mask).
  - If col_mask==0, capture goes directly to DONE: out_valid one edge after the handshake, acc unchanged.
- Undefined: fixed W_MAG_WIDTH cycles; no mask logic is synthesised.

Decomposition:
- Package bitserial_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - width helper functions (tree width, ACC_WIDTH).
- Sub-module bs_column_reduce: combinational lane select plus generate-built adder tree. Inputs are act, w_sign and the current weight-bit column; output is the signed column sum of width DATA_WIDTH+1+$clog2(VEC_LENGTH).
- Top level holds the FSM, col counter, optional mask/priority encoder, accumulator and handshakes.

Test Plan:
- Full-scale positive: VEC_LENGTH=16, all act=1, w_sign=0, w_mag=7'h7F, in_clear=1 -> out_valid after 7 edges, result=2032.
- Extreme negative: all act=-128, w_sign=1, w_mag=1 -> result=+2048, no wrap.
- Single-lane mixed-sign sequence:
  - lane0 act=5, w_sign=1, w_mag=3, others act=0, in_clear=1 -> result=-15.
  - Then test 1's vector with in_clear=0 -> result=2017.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, result constant, in_ready=0, in_valid pulses ignored. Release -> in_ready=1 one cycle later.
- Reset mid-RUN: assert reset on the 3rd RUN cycle -> next cycle out_valid=0, result=0, acc=0. A fresh vector after reset yields the correct value.
- Skip (macro defined):
  - all act=1, w_mag=7'h40 -> out_valid after 1 edge, result=1024.
  - w_mag=0 -> out_valid after 1 edge, result=prior acc.
  - Macro undefined: the same vectors take 7 edges with identical results.
